// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-access slave: oversamples the SPI pins on i_clk and turns read/write
// frames into a valid/ready register request plus a one-cycle read-response strobe.
module spi_reg_slave #(
  parameter logic async_reset = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_cs,
  input  logic        i_sclk,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_req_valid,
  output logic        o_req_write,
  output logic [31:0] o_req_addr,
  output logic [31:0] o_req_wdata,
  input  logic        i_req_ready,
  input  logic        i_resp_valid,
  input  logic [31:0] i_resp_rdata,
  output logic        o_late
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWdata, StDummy, StRdata, StSkip
  } state_e;

  localparam logic [7:0] CmdWrite = 8'h02;
  localparam logic [7:0] CmdRead  = 8'h03;

  // The reset is asynchronous regardless of the selector; it only keeps the parameter list uniform.
  if (async_reset) begin : g_async_reset
  end

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic        miso_q, skip_hi_q, is_write_q, late_q;
  logic [6:0]  cmd_sr_q;
  logic [31:0] addr_sr_q, wdata_sr_q, tx_sr_q;

  logic        req_valid_q, req_write_q, pend_q, pend_write_q, req_ours_q;
  logic [31:0] req_addr_q, req_wdata_q;

  logic        rd_wait_q, resp_ok_q;
  logic [31:0] rbuf_q;

  logic        cs_fall, cs_rise, sclk_rise, sclk_fall, shift_en;
  logic        last_bit, word_done, rd_issue, wr_issue, handshake, req_free;
  logic [7:0]  cmd_next;
  logic [31:0] addr_next, wdata_next;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= i_cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= i_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= i_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  always_comb begin
    cs_fall    = cs_prev_q & ~cs_sync_q;
    cs_rise    = ~cs_prev_q & cs_sync_q;
    sclk_rise  = sclk_sync_q & ~sclk_prev_q;
    sclk_fall  = ~sclk_sync_q & sclk_prev_q;
    shift_en   = sclk_rise & ~cs_rise & ~cs_fall;
    last_bit   = (bit_cnt_q == 3'd7);
    word_done  = last_bit && (byte_cnt_q == 2'd3);
    cmd_next   = {cmd_sr_q, mosi_sync_q};
    addr_next  = {addr_sr_q[30:0], mosi_sync_q};
    wdata_next = {wdata_sr_q[30:0], mosi_sync_q};
    rd_issue   = shift_en && (state_q == StAddr) && word_done && !is_write_q;
    wr_issue   = shift_en && (state_q == StWdata) && word_done;
    handshake  = req_valid_q && i_req_ready;
    req_free   = !req_valid_q || i_req_ready;
  end

  // Frame FSM: bit sampling on sclk rise, MISO shifting on sclk fall.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      miso_q     <= 1'b0;
      skip_hi_q  <= 1'b0;
      is_write_q <= 1'b0;
      late_q     <= 1'b0;
      cmd_sr_q   <= '0;
      addr_sr_q  <= '0;
      wdata_sr_q <= '0;
      tx_sr_q    <= '0;
    end else if (cs_rise) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      miso_q     <= 1'b0;
      skip_hi_q  <= 1'b0;
    end else if (cs_fall) begin
      state_q    <= StCmd;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      miso_q     <= 1'b0;
      skip_hi_q  <= 1'b0;
    end else if (sclk_rise && state_q != StIdle && state_q != StSkip) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (last_bit) byte_cnt_q <= byte_cnt_q + 2'd1;
      case (state_q)
        StCmd: begin
          cmd_sr_q <= cmd_next[6:0];
          if (last_bit) begin
            byte_cnt_q <= '0;
            is_write_q <= (cmd_next == CmdWrite);
            state_q    <= (cmd_next == CmdWrite || cmd_next == CmdRead) ? StAddr : StSkip;
          end
        end
        StAddr: begin
          addr_sr_q <= addr_next;
          if (word_done) state_q <= is_write_q ? StWdata : StDummy;
        end
        StWdata: begin
          wdata_sr_q <= wdata_next;
          if (word_done) state_q <= StSkip;
        end
        StDummy: begin
          if (last_bit) begin
            state_q    <= StRdata;
            byte_cnt_q <= '0;
            tx_sr_q    <= resp_ok_q ? rbuf_q : 32'hFFFF_FFFF;
            if (!resp_ok_q) late_q <= 1'b1;
          end
        end
        StRdata: begin
          if (word_done) begin
            state_q   <= StSkip;
            skip_hi_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end else if (sclk_fall) begin
      case (state_q)
        StRdata: begin
          miso_q  <= tx_sr_q[31];
          tx_sr_q <= {tx_sr_q[30:0], 1'b0};
        end
        StSkip:  miso_q <= skip_hi_q;
        default: miso_q <= 1'b0;
      endcase
    end
  end

  // A request that cannot be presented yet (previous one unaccepted) is parked as pending.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      pend_q       <= 1'b0;
      pend_write_q <= 1'b0;
      req_ours_q   <= 1'b0;
    end else begin
      if (rd_issue || wr_issue) begin
        if (req_free) begin
          req_valid_q <= 1'b1;
          req_write_q <= wr_issue;
          req_addr_q  <= wr_issue ? addr_sr_q : addr_next;
          if (wr_issue) req_wdata_q <= wdata_next;
          req_ours_q  <= rd_issue;
        end else begin
          pend_q       <= 1'b1;
          pend_write_q <= wr_issue;
        end
      end else if (pend_q && req_free) begin
        req_valid_q <= 1'b1;
        req_write_q <= pend_write_q;
        req_addr_q  <= addr_sr_q;
        if (pend_write_q) req_wdata_q <= wdata_sr_q;
        req_ours_q  <= !pend_write_q && (state_q == StDummy || state_q == StRdata);
        pend_q      <= 1'b0;
      end else if (handshake) begin
        req_valid_q <= 1'b0;
        req_ours_q  <= 1'b0;
      end
      if (cs_rise || cs_fall) req_ours_q <= 1'b0;
    end
  end

  // Only a read accepted within the current frame may load the read buffer.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rd_wait_q <= 1'b0;
      resp_ok_q <= 1'b0;
      rbuf_q    <= '0;
    end else if (cs_fall) begin
      rd_wait_q <= 1'b0;
      resp_ok_q <= 1'b0;
    end else if (cs_rise) begin
      rd_wait_q <= 1'b0;
    end else if (handshake && !req_write_q && req_ours_q) begin
      rd_wait_q <= 1'b1;
    end else if (rd_wait_q && i_resp_valid) begin
      rd_wait_q <= 1'b0;
      resp_ok_q <= 1'b1;
      rbuf_q    <= i_resp_rdata;
    end
  end

  assign o_miso      = miso_q;
  assign o_req_valid = req_valid_q;
  assign o_req_write = req_write_q;
  assign o_req_addr  = req_addr_q;
  assign o_req_wdata = req_wdata_q;
  assign o_late      = late_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed frames plus randomized read/write frames
// checked against a frame-level model of requests, MISO bytes and the late flag.
module tb_spi_reg_slave;

  localparam int Half = 8;

  logic        i_clk = 1'b0;
  logic        i_nrst, i_cs, i_sclk, i_mosi, o_miso;
  logic        o_req_valid, o_req_write, i_req_ready, i_resp_valid, o_late;
  logic [31:0] o_req_addr, o_req_wdata, i_resp_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          resp_delay = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = '0;
  bit          inject_stale = 1'b0;
  bit          late_model = 1'b0;
  logic [64:0] obs_q[$];

  spi_reg_slave #(.async_reset(1'b0)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_cs         (i_cs),
    .i_sclk       (i_sclk),
    .i_mosi       (i_mosi),
    .o_miso       (o_miso),
    .o_req_valid  (o_req_valid),
    .o_req_write  (o_req_write),
    .o_req_addr   (o_req_addr),
    .o_req_wdata  (o_req_wdata),
    .i_req_ready  (i_req_ready),
    .i_resp_valid (i_resp_valid),
    .i_resp_rdata (i_resp_rdata),
    .o_late       (o_late)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: logs handshakes due at the coming edge and plays the register-side responder.
  task automatic tick();
    logic hs_rd;
    hs_rd = 1'b0;
    if (o_req_valid && i_req_ready) begin
      obs_q.push_back({o_req_write, o_req_addr, o_req_wdata});
      hs_rd = !o_req_write;
    end
    @(posedge i_clk);
    #1;
    i_resp_valid = 1'b0;
    if (hs_rd && resp_delay > 0) resp_cnt = resp_delay;
    if (inject_stale) begin
      i_resp_valid = 1'b1;
      i_resp_rdata = 32'hBAD0_BAD0;
      inject_stale = 1'b0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        i_resp_valid = 1'b1;
        i_resp_rdata = resp_data;
      end
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      i_mosi = tx[i];
      repeat (Half) tick();
      i_sclk = 1'b1;
      rx[i]  = o_miso;
      repeat (Half) tick();
      i_sclk = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, output logic [31:0] r);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      spi_byte(w[i*8 +: 8], b);
      r[i*8 +: 8] = b;
    end
  endtask

  task automatic cs_begin();
    i_cs = 1'b0;
    repeat (Half) tick();
  endtask

  task automatic cs_end();
    repeat (Half) tick();
    i_cs = 1'b1;
    repeat (2 * Half) tick();
  endtask

  task automatic expect_req(input string tag, input logic wr, input logic [31:0] a,
                            input logic [31:0] d);
    logic [64:0] r;
    check_eq({tag, "_hs_count"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      check_eq({tag, "_write"}, 32'(r[64]), 32'(wr));
      check_eq({tag, "_addr"}, r[63:32], a);
      if (wr) check_eq({tag, "_wdata"}, r[31:0], d);
    end
    obs_q.delete();
  endtask

  task automatic expect_no_req(input string tag);
    check_eq({tag, "_no_req"}, 32'(obs_q.size()) | 32'(o_req_valid), 32'd0);
    obs_q.delete();
  endtask

  task automatic run_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [31:0] r;
    cs_begin();
    spi_byte(8'h02, b);
    send_word(a, r);
    send_word(d, r);
    cs_end();
    expect_req(tag, 1'b1, a, d);
    check_eq({tag, "_miso_idle"}, 32'(o_miso), 32'd0);
  endtask

  task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] data,
                          input int delay, input bit stale);
    logic [7:0]  b, dmy, tail;
    logic [31:0] r, rx, exp_rx;
    bit          on_time;
    // A response is in time only if it arrives well inside the dummy byte.
    on_time = (delay > 0) && (delay <= 60);
    exp_rx  = on_time ? data : 32'hFFFF_FFFF;
    if (!on_time) late_model = 1'b1;
    resp_delay = delay;
    resp_data  = data;
    cs_begin();
    spi_byte(8'h03, b);
    spi_byte(a[31:24], b);
    if (stale) inject_stale = 1'b1;
    spi_byte(a[23:16], b);
    spi_byte(a[15:8], b);
    spi_byte(a[7:0], b);
    spi_byte(8'h00, dmy);
    send_word($urandom, rx);
    spi_byte(8'h00, tail);
    cs_end();
    check_eq({tag, "_dummy"}, 32'(dmy), 32'h0);
    check_eq({tag, "_rdata"}, rx, exp_rx);
    check_eq({tag, "_tail"}, 32'(tail), 32'hFF);
    check_eq({tag, "_late"}, 32'(o_late), 32'(late_model));
    check_eq({tag, "_miso_idle"}, 32'(o_miso), 32'd0);
    expect_req(tag, 1'b0, a, 32'h0);
    resp_delay = 0;
  endtask

  task automatic run_partial(input string tag, input logic [7:0] cmd, input int nbytes);
    logic [7:0] b, acc;
    spi_byte(cmd, acc);
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(8'($urandom), b);
      acc = acc | b;
    end
    check_eq({tag, "_miso_bytes"}, 32'(acc), 32'h0);
  endtask

  initial begin
    logic [31:0] a, d, hold_a, hold_d;
    int          kind, stable;

    i_nrst = 1'b0;
    i_cs = 1'b1;
    i_sclk = 1'b0;
    i_mosi = 1'b0;
    i_req_ready = 1'b1;
    i_resp_valid = 1'b0;
    i_resp_rdata = '0;
    repeat (4) tick();
    check_eq("rst_miso", 32'(o_miso), 32'd0);
    check_eq("rst_valid", 32'(o_req_valid), 32'd0);
    check_eq("rst_write", 32'(o_req_write), 32'd0);
    check_eq("rst_addr", o_req_addr, 32'd0);
    check_eq("rst_wdata", o_req_wdata, 32'd0);
    check_eq("rst_late", 32'(o_late), 32'd0);
    i_nrst = 1'b1;
    repeat (4) tick();

    run_write("wr_basic", 32'h1000_0004, 32'hDEAD_BEEF);
    run_read("rd_ontime", 32'h0000_0010, 32'h1234_5678, 3, 1'b0);
    run_read("rd_withheld", 32'h0000_0010, 32'h1234_5678, 0, 1'b0);
    // A response arriving after the frame, and another before the next read is accepted.
    inject_stale = 1'b1;
    repeat (4) tick();
    run_read("rd_stale", 32'h0000_0010, 32'h1234_5678, 0, 1'b1);
    run_read("rd_late_sticky", 32'h0000_0020, 32'hCAFE_F00D, 5, 1'b0);

    hold_a = 32'hA5A5_0040;
    hold_d = 32'h0BAD_CAFE;
    i_req_ready = 1'b0;
    cs_begin();
    begin
      logic [7:0]  b;
      logic [31:0] r;
      spi_byte(8'h02, b);
      send_word(hold_a, r);
      send_word(hold_d, r);
    end
    cs_end();
    stable = 0;
    repeat (20) begin
      if (o_req_valid === 1'b1 && o_req_write === 1'b1 && o_req_addr === hold_a &&
          o_req_wdata === hold_d) stable++;
      tick();
    end
    check_eq("hold_stable", 32'(stable), 32'd20);
    check_eq("hold_no_hs", 32'(obs_q.size()), 32'd0);
    i_req_ready = 1'b1;
    for (int i = 0; i < 10 && obs_q.size() == 0; i++) tick();
    repeat (4) tick();
    expect_req("hold", 1'b1, hold_a, hold_d);

    cs_begin();
    run_partial("bad_cmd", 8'h5A, 8);
    cs_end();
    expect_no_req("bad_cmd");
    check_eq("bad_cmd_miso_idle", 32'(o_miso), 32'd0);

    cs_begin();
    run_partial("part_addr", 8'h02, 2);
    cs_end();
    expect_no_req("part_addr");
    check_eq("part_addr_miso_idle", 32'(o_miso), 32'd0);

    cs_begin();
    run_partial("rst_mid", 8'h03, 2);
    i_nrst = 1'b0;
    repeat (3) tick();
    check_eq("rst_mid_late", 32'(o_late), 32'd0);
    check_eq("rst_mid_miso", 32'(o_miso), 32'd0);
    i_cs = 1'b1;
    repeat (4) tick();
    i_nrst = 1'b1;
    late_model = 1'b0;
    repeat (2 * Half) tick();
    expect_no_req("rst_mid");
    run_write("wr_after_rst", 32'h0000_0100, 32'h5555_AAAA);
    run_read("rd_after_rst", 32'h0000_0104, 32'h89AB_CDEF, 10, 1'b0);

    for (int f = 0; f < 10; f++) begin
      a = $urandom;
      d = $urandom;
      if ($urandom_range(1, 0) == 0) begin
        run_write($sformatf("rnd%0d_wr", f), a, d);
      end else begin
        kind = int'($urandom_range(3, 0));
        if (kind == 0) run_read($sformatf("rnd%0d_rd", f), a, d, 0, 1'b0);
        else if (kind == 1) run_read($sformatf("rnd%0d_rd", f), a, d,
                                     int'($urandom_range(400, 300)), 1'b0);
        else run_read($sformatf("rnd%0d_rd", f), a, d, int'($urandom_range(60, 1)), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
